icdf_seg_normalizer: RTL

- Sits directly downstream of the 64-bit leading-zero detector in the ICDF Gaussian RNG datapath.
- Takes the same 61-bit uniform magnitude fed to the LZD, plus a sign bit, and aligns it with the LZD's registered zero_pos one cycle later.
- Normalises the magnitude with a 2-stage pipelined barrel shift so the leading one is removed.
- Emits segment address (= leading-zero count), FRAC_W fraction bits after the leading one, sign, and a zero flag, for the coefficient-ROM / polynomial stage.

---
 rtl/icdf_seg_normalizer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/icdf_seg_normalizer.sv
// icdf_seg_normalizer: aligns a 61-bit magnitude with the LZD's registered zero_pos and
// normalises it in two shift stages; `ICDF_SATCNT_EN adds a saturating zero-sample counter.
module icdf_seg_normalizer #(
  parameter int FRAC_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [61:0]       u_in,
  input  logic [5:0]        zero_pos,
  output logic              out_valid,
  output logic [5:0]        seg_addr,
  output logic [FRAC_W-1:0] frac,
  output logic              sign_out,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  sat_cnt
);

  logic              v0_q, v0_d;
  logic [60:0]       m_q, m_d;
  logic              s0_q, s0_d;
  logic              v1_q, v1_d;
  logic [5:0]        zp_q, zp_d;
  logic [60:0]       c_q, c_d;
  logic              s1_q, s1_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        seg_addr_q, seg_addr_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic [5:0]        zp_clamp_s;
  logic [60:0]       f_s;

  // Next-state for all three pipeline stages; data loads only under its stage valid
  always_comb begin
    v0_d        = en;
    m_d         = m_q;
    s0_d        = s0_q;
    v1_d        = v0_q;
    zp_d        = zp_q;
    c_d         = c_q;
    s1_d        = s1_q;
    out_valid_d = v1_q;
    seg_addr_d  = seg_addr_q;
    frac_d      = frac_q;
    sign_d      = sign_q;
    zero_d      = zero_q;

    // LZD codes 62/63 cannot occur for a 61-bit operand; pin them to the all-zero code
    zp_clamp_s = (zero_pos > 6'd61) ? 6'd61 : zero_pos;
    f_s        = c_q << zp_q[2:0];

    if (en) begin
      m_d  = u_in[60:0];
      s0_d = u_in[61];
    end else begin
      m_d  = m_q;
      s0_d = s0_q;
    end

    if (v0_q) begin
      zp_d = zp_clamp_s;
      c_d  = m_q << {zp_clamp_s[5:3], 3'b000};
      s1_d = s0_q;
    end else begin
      zp_d = zp_q;
      c_d  = c_q;
      s1_d = s1_q;
    end

    if (v1_q) begin
      seg_addr_d = zp_q;
      frac_d     = FRAC_W'(f_s >> (60 - FRAC_W));
      sign_d     = s1_q;
      zero_d     = (zp_q == 6'd61);
    end else begin
      seg_addr_d = seg_addr_q;
      frac_d     = frac_q;
      sign_d     = sign_q;
      zero_d     = zero_q;
    end
  end

  // Pipeline and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      m_q         <= 61'd0;
      s0_q        <= 1'b0;
      v1_q        <= 1'b0;
      zp_q        <= 6'd0;
      c_q         <= 61'd0;
      s1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      seg_addr_q  <= 6'd0;
      frac_q      <= {FRAC_W{1'b0}};
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      m_q         <= m_d;
      s0_q        <= s0_d;
      v1_q        <= v1_d;
      zp_q        <= zp_d;
      c_q         <= c_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      seg_addr_q  <= seg_addr_d;
      frac_q      <= frac_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign seg_addr  = seg_addr_q;
  assign frac      = frac_q;
  assign sign_out  = sign_q;
  assign zero_flag = zero_q;

`ifdef ICDF_SATCNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Count zero samples entering the output stage, sticking at all-ones
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (v1_q && (zp_q == 6'd61) && (sat_cnt_q != {CNT_W{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Saturation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = {CNT_W{1'b0}};
`endif

endmodule
